drum_step_sequencer: RTL and testbench

- Step sequencer that drives the per-voice sample counters (kick, snare, hat), one 16-bit sample counter per voice.
- Holds a NUM_VOICES x NUM_STEPS trigger pattern and divides clk down to the shared sample-rate enable `en`.
- Advances a step pointer every STEP_SAMPLES sample ticks and emits one-cycle `go` pulses to the voices armed at each step.
- Tracks each voice's busy state from the voice counter outputs, so stop drains cleanly without truncating a playing voice.

---
 rtl/drum_pkg.sv | 26 ++
 rtl/sample_tick_gen.sv | 40 ++++
 rtl/drum_step_sequencer.sv | 153 +++++++++++++++
 tb/tb_drum_step_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// ============================================================================
//  drum_pkg
//  Shared state encodings, default timing constants and voice indices.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package drum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int          c_sample_div   = 1136;
  localparam int          c_step_samples = 11025;
  localparam logic [15:0] c_maxcount     = 16'd43840;

  localparam int c_kick  = 0;
  localparam int c_snare = 1;
  localparam int c_hat   = 2;

endpackage

`default_nettype wire

// File: rtl/sample_tick_gen.sv
// ============================================================================
//  sample_tick_gen
//  Divides clk down to a one-cycle sample tick every SAMPLE_DIV cycles.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1136
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int              c_dw   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [c_dw-1:0] c_last = c_dw'(SAMPLE_DIV - 1);

  logic [c_dw-1:0] r_div;
  logic            w_wrap;

  assign w_wrap = (r_div == c_last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
    end else if (!enable || w_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Gated by enable so a stale divider value can never tick while stopped.
  assign tick = enable && w_wrap;

endmodule

`default_nettype wire

// File: rtl/drum_step_sequencer.sv
// ============================================================================
//  drum_step_sequencer
//  Pattern-driven step sequencer issuing retrigger pulses to voice counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module drum_step_sequencer
  import drum_pkg::*;
#(
  parameter int          NUM_VOICES   = 3,
  parameter int          NUM_STEPS    = 16,
  parameter int          SAMPLE_DIV   = c_sample_div,
  parameter int          STEP_SAMPLES = c_step_samples,
  parameter logic [15:0] MAXCOUNT     = c_maxcount
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         run,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_voice,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_step,
  input  logic                         wr_data,
  input  logic [16*NUM_VOICES-1:0]     voice_count,
  output logic [NUM_VOICES-1:0]        go,
  output logic                         en,
  output logic [$clog2(NUM_STEPS)-1:0] step,
  output logic [NUM_VOICES-1:0]        busy,
  output logic                         playing
);

  localparam int               c_sw        = $clog2(NUM_STEPS);
  localparam int               c_scw       = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [c_scw-1:0] c_scnt_last = c_scw'(STEP_SAMPLES - 1);

  state_t                                r_state;
  logic [NUM_VOICES-1:0][NUM_STEPS-1:0]  r_pattern;
  logic [c_sw-1:0]                       r_step;
  logic [c_scw-1:0]                      r_scnt;
  logic [NUM_VOICES-1:0]                 r_go;
  logic [NUM_VOICES-1:0]                 r_busy;
  logic                                  r_playing;

  logic                  w_tick;
  logic                  w_enter_play;
  logic                  w_advance;
  logic                  w_div_enable;
  logic [c_sw-1:0]       w_step_next;
  logic [NUM_VOICES-1:0] w_col_zero;
  logic [NUM_VOICES-1:0] w_col_next;
  logic [NUM_VOICES-1:0] w_go_next;
  logic [NUM_VOICES-1:0] w_done;

  assign w_enter_play = run && (r_state != PLAY);
  assign w_div_enable = (r_state != IDLE) && !w_enter_play;
  assign w_step_next  = r_step + 1'b1;
  assign w_advance    = (r_state == PLAY) && run && w_tick && (r_scnt == c_scnt_last);

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .enable (w_div_enable),
    .tick   (w_tick)
  );

  always_comb begin
    w_col_zero = '0;
    w_col_next = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_col_zero[v] = r_pattern[v][0];
      w_col_next[v] = r_pattern[v][w_step_next];
    end
  end

  assign w_go_next = w_enter_play ? w_col_zero :
                     w_advance    ? w_col_next : '0;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign w_done[v] = (voice_count[16*v +: 16] == MAXCOUNT);
  end

  // Pattern reads above use the pre-edge value, so a same-cycle write lands a lap later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pattern <= '0;
    end else if (wr_en && (int'(wr_voice) < NUM_VOICES)) begin
      r_pattern[wr_voice][wr_step] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_scnt    <= '0;
      r_go      <= '0;
      r_busy    <= '0;
      r_playing <= 1'b0;
    end else begin
      r_go   <= w_go_next;
      // A pending or current retrigger keeps the voice busy over a terminal count.
      r_busy <= (r_busy & ~(w_done & ~r_go)) | w_go_next;

      if (w_enter_play) begin
        r_step <= '0;
        r_scnt <= '0;
      end else if (w_advance) begin
        r_step <= w_step_next;
        r_scnt <= '0;
      end else if ((r_state == PLAY) && w_tick) begin
        r_scnt <= r_scnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (run) begin
            r_state   <= PLAY;
            r_playing <= 1'b1;
          end
        end
        PLAY: begin
          if (!run) begin
            r_state   <= DRAIN;
            r_playing <= 1'b0;
          end
        end
        DRAIN: begin
          if (run) begin
            r_state   <= PLAY;
            r_playing <= 1'b1;
          end else if (r_busy == '0) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign go      = r_go;
  assign en      = w_tick;
  assign step    = r_step;
  assign busy    = r_busy;
  assign playing = r_playing;

endmodule

`default_nettype wire

// File: tb/tb_drum_step_sequencer.sv
// ============================================================================
//  tb_drum_step_sequencer
//  Directed bench with a small voice-counter model (SAMPLE_DIV=4, STEP_SAMPLES=3).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_drum_step_sequencer;

  localparam int          c_nv  = 3;
  localparam logic [15:0] c_max = 16'd5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_voice = '0;
  logic [3:0]  wr_step = '0;
  logic        wr_data = 1'b0;
  logic [47:0] voice_count;
  logic [2:0]  go;
  logic        en;
  logic [3:0]  step;
  logic [2:0]  busy;
  logic        playing;

  logic [15:0] vc [c_nv];
  logic        ovr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int off     = 0;

  drum_step_sequencer #(
    .NUM_VOICES   (3),
    .NUM_STEPS    (16),
    .SAMPLE_DIV   (4),
    .STEP_SAMPLES (3),
    .MAXCOUNT     (c_max)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .run         (run),
    .wr_en       (wr_en),
    .wr_voice    (wr_voice),
    .wr_step     (wr_step),
    .wr_data     (wr_data),
    .voice_count (voice_count),
    .go          (go),
    .en          (en),
    .step        (step),
    .busy        (busy),
    .playing     (playing)
  );

  always #5 clk = ~clk;

  // Voice counter model: restart on go, count on en, park at the terminal count.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int v = 0; v < c_nv; v++) vc[v] <= c_max;
    end else begin
      for (int v = 0; v < c_nv; v++) begin
        if (go[v]) vc[v] <= 16'd0;
        else if (en && vc[v] < c_max) vc[v] <= vc[v] + 16'd1;
      end
    end
  end

  assign voice_count = {vc[2], vc[1], (ovr ? c_max : vc[0])};

  typedef struct {
    int         off;
    logic [2:0] go;
    logic       en;
    logic [3:0] step;
    logic       chk_busy;
    logic [2:0] busy;
  } vec_t;

  vec_t tv [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t off=%0d)", name, act, exp, $time, off);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    off++;
  endtask

  task automatic run_to(input int target);
    while (off < target) cyc();
  endtask

  task automatic do_reset();
    run    = 1'b0;
    wr_en  = 1'b0;
    ovr    = 1'b0;
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic wr(input logic [1:0] v, input logic [3:0] s, input logic d);
    wr_en    = 1'b1;
    wr_voice = v;
    wr_step  = s;
    wr_data  = d;
    cyc();
    wr_en    = 1'b0;
  endtask

  // Raise run in IDLE; returns in the first PLAY cycle with off = 0.
  task automatic start_play();
    run = 1'b1;
    cyc();
    off = 0;
  endtask

  initial begin
    int ecnt;

    tv[0]  = '{0,  3'b001, 1'b0, 4'd0, 1'b0, 3'b000};
    tv[1]  = '{1,  3'b000, 1'b0, 4'd0, 1'b1, 3'b001};
    tv[2]  = '{3,  3'b000, 1'b1, 4'd0, 1'b1, 3'b001};
    tv[3]  = '{4,  3'b000, 1'b0, 4'd0, 1'b1, 3'b001};
    tv[4]  = '{7,  3'b000, 1'b1, 4'd0, 1'b1, 3'b001};
    tv[5]  = '{11, 3'b000, 1'b1, 4'd0, 1'b1, 3'b001};
    tv[6]  = '{12, 3'b000, 1'b0, 4'd1, 1'b1, 3'b001};
    tv[7]  = '{15, 3'b000, 1'b1, 4'd1, 1'b1, 3'b001};
    tv[8]  = '{20, 3'b000, 1'b0, 4'd1, 1'b1, 3'b001};
    tv[9]  = '{21, 3'b000, 1'b0, 4'd1, 1'b1, 3'b000};
    tv[10] = '{23, 3'b000, 1'b1, 4'd1, 1'b1, 3'b000};
    tv[11] = '{24, 3'b000, 1'b0, 4'd2, 1'b1, 3'b000};
    tv[12] = '{47, 3'b000, 1'b1, 4'd3, 1'b1, 3'b000};
    tv[13] = '{48, 3'b001, 1'b0, 4'd4, 1'b0, 3'b000};
    tv[14] = '{49, 3'b000, 1'b0, 4'd4, 1'b1, 3'b001};
    tv[15] = '{60, 3'b000, 1'b0, 4'd5, 1'b1, 3'b001};

    // Reset state
    #2;
    check("rst_go", 32'(go), 0);
    check("rst_en", 32'(en), 0);
    check("rst_step", 32'(step), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_playing", 32'(playing), 0);

    // 1: kick at steps 0 and 4, timing table
    do_reset();
    wr(2'd0, 4'd0, 1'b1);
    wr(2'd0, 4'd4, 1'b1);
    start_play();
    check("t1_playing", 32'(playing), 1);
    for (int i = 0; i < 16; i++) begin
      run_to(tv[i].off);
      check($sformatf("t1_go@%0d", tv[i].off), 32'(go), 32'(tv[i].go));
      check($sformatf("t1_en@%0d", tv[i].off), 32'(en), 32'(tv[i].en));
      check($sformatf("t1_step@%0d", tv[i].off), 32'(step), 32'(tv[i].step));
      if (tv[i].chk_busy)
        check($sformatf("t1_busy@%0d", tv[i].off), 32'(busy), 32'(tv[i].busy));
    end

    // 2: step wrap with snare at 0 and 15
    do_reset();
    wr(2'd1, 4'd0, 1'b1);
    wr(2'd1, 4'd15, 1'b1);
    start_play();
    check("t2_go0", 32'(go), 32'b010);
    ecnt = 0;
    while (off < 180) begin
      cyc();
      if (en) ecnt++;
    end
    check("t2_en_count", 32'(ecnt), 45);
    check("t2_step15", 32'(step), 15);
    check("t2_go15", 32'(go), 32'b010);
    run_to(191);
    check("t2_go_gap", 32'(go), 0);
    run_to(192);
    check("t2_wrap_step", 32'(step), 0);
    check("t2_wrap_go", 32'(go), 32'b010);

    // 3: busy / drain
    do_reset();
    wr(2'd0, 4'd0, 1'b1);
    start_play();
    check("t3_go", 32'(go), 32'b001);
    run = 1'b0;
    run_to(1);
    check("t3_playing", 32'(playing), 0);
    run_to(3);
    check("t3_drain_en", 32'(en), 1);
    run_to(19);
    check("t3_drain_en19", 32'(en), 1);
    check("t3_step_frozen", 32'(step), 0);
    run_to(20);
    check("t3_busy20", 32'(busy), 32'b001);
    run_to(21);
    check("t3_busy21", 32'(busy), 0);
    run_to(23);
    check("t3_idle_en", 32'(en), 0);
    run_to(27);
    check("t3_idle_en27", 32'(en), 0);

    // 4: retrigger coincides with terminal count
    do_reset();
    wr(2'd0, 4'd0, 1'b1);
    wr(2'd0, 4'd1, 1'b1);
    ovr = 1'b1;
    start_play();
    check("t4_go0", 32'(go), 32'b001);
    run_to(1);
    check("t4_busy_hold", 32'(busy), 32'b001);
    run_to(2);
    check("t4_busy_clr", 32'(busy), 0);
    run_to(12);
    check("t4_go12", 32'(go), 32'b001);
    run_to(13);
    check("t4_busy_hold2", 32'(busy), 32'b001);
    run_to(14);
    check("t4_busy_clr2", 32'(busy), 0);

    // 5: write collides with step-update read
    do_reset();
    start_play();
    run_to(11);
    check("t5_update_en", 32'(en), 1);
    check("t5_update_step", 32'(step), 0);
    wr(2'd2, 4'd1, 1'b1);
    check("t5_step1", 32'(step), 1);
    check("t5_no_go", 32'(go), 0);
    run_to(204);
    check("t5_lap_step", 32'(step), 1);
    check("t5_lap_go", 32'(go), 32'b100);

    // 6: async reset mid-play
    do_reset();
    wr(2'd0, 4'd0, 1'b1);
    wr(2'd0, 4'd1, 1'b1);
    start_play();
    run_to(15);
    check("t6_pre_en", 32'(en), 1);
    check("t6_pre_step", 32'(step), 1);
    check("t6_pre_busy", 32'(busy), 32'b001);
    #2;
    resetn = 1'b0;
    run    = 1'b0;
    #1;
    check("t6_go", 32'(go), 0);
    check("t6_en", 32'(en), 0);
    check("t6_step", 32'(step), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_playing", 32'(playing), 0);
    #2;
    resetn = 1'b1;
    cyc();
    start_play();
    check("t6_pat0", 32'(go), 0);
    run_to(12);
    check("t6_pat1_step", 32'(step), 1);
    check("t6_pat1", 32'(go), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
